// File: rtl/fetch_unit_pkg.sv
// Shared SimpleRISC definitions used by the fetch, operand-fetch and execute
// stages: opcode values, instruction field positions, the canonical NOP word
// and small field-extraction helpers.
package fetch_unit_pkg;

    // Instruction field positions (opcode, immediate flag, register fields).
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int IMM_BIT = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 18;
    localparam int RS2_MSB = 17;
    localparam int RS2_LSB = 14;

    localparam logic [4:0]  OPC_NOP  = 5'b01101;
    localparam logic [4:0]  OPC_HALT = 5'b11111;

    // Bubble word: NOP opcode, all other fields zero (32'h6800_0000).
    localparam logic [31:0] NOP_INST = {OPC_NOP, 27'd0};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_word_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic is_halt(input logic [31:0] word);
        return (opcode_of(word) == OPC_HALT);
    endfunction

    function automatic logic is_imm(input logic [31:0] word);
        return word[IMM_BIT];
    endfunction

    function automatic logic [3:0] rd_of(input logic [31:0] word);
        return word[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] rs1_of(input logic [31:0] word);
        return word[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [3:0] rs2_of(input logic [31:0] word);
        return word[RS2_MSB:RS2_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_skid_buffer.sv
// One-entry skid buffer holding a {pc, inst} pair.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture in_pc/in_inst and mark the entry valid
//   drain               entry consumed downstream, mark it empty
//   clear               discard the entry (wins over load and drain)
//   in_pc, in_inst      word to capture
//   valid               entry holds a word
//   out_pc, out_inst    stored word
module fetch_unit_skid_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        clear,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;

    // Entry storage: clear beats load, load beats drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= 32'd0;
            inst_r  <= 32'd0;
        end else if (clear) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= in_pc;
            inst_r  <= in_inst;
        end else if (drain) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid    = valid_r;
    assign out_pc   = pc_r;
    assign out_inst = inst_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and delivers pc/inst pairs through the IF/OF register.
// Stalls are absorbed by a one-entry skid buffer; redirects squash the wrong
// path by injecting NOP bubbles.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   stall                    operand fetch cannot accept; IF/OF holds
//   redirect, redirect_pc    taken control transfer and its target
//   imem_en, imem_addr       memory read strobe and address
//   imem_rdata               data for the address issued last cycle
//   pc, inst, inst_valid     IF/OF register
//   fetch_count              count of valid deliveries (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h0000_0001,
    parameter logic [31:0] NOP_INST = fetch_unit_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);
    import fetch_unit_pkg::*;

    logic [31:0] fpc_r;
    logic        inflight_r;
    logic [31:0] inflight_pc_r;
    logic        kill_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        inst_valid_r;
    logic [31:0] fetch_count_r;

    logic        issue_s;
    logic        resp_live_s;
    logic        sk_load_s;
    logic        sk_drain_s;
    logic        sk_clear_s;
    logic        sk_valid_s;
    logic [31:0] sk_pc_s;
    logic [31:0] sk_inst_s;

    // Issue and skid control. No issue while the skid is full or a stall is
    // pending, which is what keeps the single skid entry from overflowing.
    always_comb begin
        issue_s     = rst_n & ~stall & ~sk_valid_s & ~redirect;
        resp_live_s = inflight_r & ~kill_r;
        sk_clear_s  = redirect;
        sk_load_s   = stall & resp_live_s & ~redirect;
        sk_drain_s  = ~stall & sk_valid_s & ~redirect;
    end

    fetch_unit_skid_buffer u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sk_load_s),
        .drain    (sk_drain_s),
        .clear    (sk_clear_s),
        .in_pc    (inflight_pc_r),
        .in_inst  (imem_rdata),
        .valid    (sk_valid_s),
        .out_pc   (sk_pc_s),
        .out_inst (sk_inst_s)
    );

    // Fetch pointer and outstanding-read tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_r         <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'd0;
            kill_r        <= 1'b0;
        end else if (redirect) begin
            fpc_r      <= redirect_pc;
            inflight_r <= 1'b0;
            kill_r     <= inflight_r;
        end else if (issue_s) begin
            fpc_r         <= fpc_r + PC_STEP;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fpc_r;
            kill_r        <= 1'b0;
        end else begin
            inflight_r <= 1'b0;
            kill_r     <= 1'b0;
        end
    end

    // IF/OF register and delivery counter; redirect squashes even under stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r          <= 32'd0;
            inst_r        <= NOP_INST;
            inst_valid_r  <= 1'b0;
            fetch_count_r <= 32'd0;
        end else if (redirect) begin
            inst_r       <= NOP_INST;
            inst_valid_r <= 1'b0;
        end else if (stall) begin
            inst_valid_r <= inst_valid_r;
        end else if (sk_valid_s) begin
            pc_r          <= sk_pc_s;
            inst_r        <= sk_inst_s;
            inst_valid_r  <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
        end else if (resp_live_s) begin
            pc_r          <= inflight_pc_r;
            inst_r        <= imem_rdata;
            inst_valid_r  <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
        end else begin
            inst_r       <= NOP_INST;
            inst_valid_r <= 1'b0;
        end
    end

    assign imem_en     = issue_s;
    assign imem_addr   = fpc_r;
    assign pc          = pc_r;
    assign inst        = inst_r;
    assign inst_valid  = inst_valid_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stall/redirect/
// reset traffic, checked against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h6800_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_fpc;
    logic [31:0] m_issued[$];
    logic [31:0] m_held[$];
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .fetch_count (fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'd100;
    endfunction

    // Synchronous instruction memory; garbage when not read.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fpc   = 32'd0;
        m_issued.delete();
        m_held.delete();
        m_pc    = 32'd0;
        m_inst  = NOP;
        m_valid = 1'b0;
        m_count = 32'd0;
    endtask

    task automatic deliver(input logic [31:0] a);
        m_pc    = a;
        m_inst  = mem_word(a);
        m_valid = 1'b1;
        m_count = m_count + 32'd1;
    endtask

    // One clock: drive inputs, check the read request, advance the model,
    // then check the IF/OF outputs half a cycle after the edge.
    task automatic cycle(input logic r, input logic s, input logic d, input logic [31:0] rpc);
        logic        will_issue;
        logic        has_arr;
        logic [31:0] arrived;
        rst_n       = r;
        stall       = s;
        redirect    = d;
        redirect_pc = rpc;
        #1;
        will_issue = r && !d && !s && (m_held.size() == 0);
        check("imem_en", {31'd0, imem_en}, {31'd0, will_issue});
        if (will_issue) check("imem_addr", imem_addr, m_fpc);
        @(posedge clk);
        has_arr = (m_issued.size() > 0);
        arrived = 32'd0;
        if (has_arr) arrived = m_issued.pop_front();
        if (!r) begin
            model_reset();
        end else if (d) begin
            m_held.delete();
            m_inst  = NOP;
            m_valid = 1'b0;
            m_fpc   = rpc;
        end else begin
            if (s) begin
                if (has_arr) m_held.push_back(arrived);
            end else if (m_held.size() > 0) begin
                deliver(m_held.pop_front());
            end else if (has_arr) begin
                deliver(arrived);
            end else begin
                m_inst  = NOP;
                m_valid = 1'b0;
            end
            if (will_issue) begin
                m_issued.push_back(m_fpc);
                m_fpc = m_fpc + 32'd1;
            end
        end
        @(negedge clk);
        check("inst", inst, m_inst);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        if (m_valid) check("pc", pc, m_pc);
        check("fetch_count", fetch_count, m_count);
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        model_reset();
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        // Reset release: 0/100, 1/101, 2/102
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Stall 3 cycles while pc=2 is shown
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Redirect to 40 while pc=5 is shown
        cycle(1'b1, 1'b0, 1'b1, 32'd40);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Redirect together with stall while the skid buffer is full
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 32'd40);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Reset during a stall with a full skid buffer
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Fetch address wraps past 32'hFFFF_FFFF
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Back-to-back redirects
        cycle(1'b1, 1'b0, 1'b1, 32'd10);
        cycle(1'b1, 1'b0, 1'b1, 32'd20);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        s;
            logic        d;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) != 0);
            s   = ($urandom_range(0, 3) == 0);
            d   = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                              : 32'($urandom_range(0, 255));
            cycle(r, s, d, rpc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
